// File: rtl/calc_issue_ctrl_if.sv
// Command, calculator and result bundle for calc_issue_ctrl.
// The slave modport is the controller side. The master modport is the host/calculator side.
interface calc_issue_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [2:0]       operation;
   logic [WIDTH-1:0] opa_calc;
   logic [WIDTH-1:0] opb_calc;
   logic [WIDTH-1:0] out_calc;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [TAG_W-1:0] res_tag;
   logic             res_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, out_calc, res_ready,
      output cmd_ready, operation, opa_calc, opb_calc, res_valid, res_data, res_tag, res_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, out_calc, res_ready,
      input  cmd_ready, operation, opa_calc, opb_calc, res_valid, res_data, res_tag, res_err
   );
endinterface

// File: rtl/calc_issue_ctrl.sv
// Command FIFO plus an issue FSM in front of the integer calculator.
// It holds the operands for CALC_LAT edges, samples out_calc, and returns a tagged result.
module calc_issue_ctrl #(
   parameter int WIDTH      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CALC_LAT   = 2,
   parameter int TAG_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   calc_issue_ctrl_if.slave   bus,
   output logic               busy
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int LW = (CALC_LAT > 1) ? $clog2(CALC_LAT + 1) : 1;

   typedef struct packed {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   entry_t           mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    count_q, count_d;
   logic [TAG_W-1:0] tag_q;
   state_t           state_q, state_d;
   logic [LW-1:0]    wcnt_q, wcnt_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [TAG_W-1:0] res_tag_q, res_tag_d;
   logic             res_err_q, res_err_d;
   logic             push, pop;
   entry_t           head;

   // A full FIFO refuses a push, even when a pop happens on the same edge.
   assign bus.cmd_ready = (count_q < CW'(FIFO_DEPTH));
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign head          = mem_q[rd_q];

   assign bus.operation = op_q;
   assign bus.opa_calc  = opa_q;
   assign bus.opb_calc  = opb_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_tag   = res_tag_q;
   assign bus.res_err   = res_err_q;
   assign busy          = (state_q != IDLE) | (count_q != '0);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: tag_q};
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      op_d        = op_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      cur_tag_d   = cur_tag_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_tag_d   = res_tag_q;
      res_err_d   = res_err_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
               // Faulting commands complete here and never reach the calculator.
               if (head.op > 3'b100 || ((head.op == 3'b011 || head.op == 3'b100) && head.b == '0)) begin
                  res_data_d  = (head.op == 3'b011) ? '1 : (head.op == 3'b100) ? head.a : '0;
                  res_err_d   = 1'b1;
                  res_valid_d = 1'b1;
                  res_tag_d   = head.tag;
                  state_d     = DONE;
               end else begin
                  op_d      = head.op;
                  opa_d     = head.a;
                  opb_d     = head.b;
                  cur_tag_d = head.tag;
                  wcnt_d    = LW'(CALC_LAT);
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            wcnt_d = wcnt_q - 1'b1;
            if (wcnt_q == LW'(1)) begin
               res_data_d  = bus.out_calc;
               res_err_d   = 1'b0;
               res_valid_d = 1'b1;
               res_tag_d   = cur_tag_q;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         tag_q       <= '0;
         state_q     <= IDLE;
         wcnt_q      <= '0;
         op_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         cur_tag_q   <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
         res_err_q   <= 1'b0;
      end else begin
         if (push) begin
            wr_q  <= wr_q + 1'b1;
            tag_q <= tag_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         count_q     <= count_d;
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         op_q        <= op_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         cur_tag_q   <= cur_tag_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_tag_q   <= res_tag_d;
         res_err_q   <= res_err_d;
      end
   end
endmodule

// File: tb/tb_calc_issue_ctrl.sv
// Self-checking bench for calc_issue_ctrl: a vector table, a result scoreboard and directed corner cases.
module tb_calc_issue_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   errors = 0;
   int   checks = 0;
   int   nres   = 0;
   logic [7:0]  tag_m;
   logic [7:0]  last_tag;
   logic [15:0] last_a;

   calc_issue_ctrl_if #(.WIDTH(16), .TAG_W(8)) bus ();

   calc_issue_ctrl #(.WIDTH(16), .FIFO_DEPTH(4), .CALC_LAT(2), .TAG_W(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] calc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return 16'(a * b);
         3'd3:    return (b == 0) ? 16'hFFFF : a / b;
         3'd4:    return (b == 0) ? a : a % b;
         default: return 16'h0;
      endcase
   endfunction

   // Stand-in for the calculator stage driven by the controller's operand registers.
   always_comb bus.out_calc = calc(bus.operation, bus.opa_calc, bus.opb_calc);

   typedef struct {logic [15:0] d; logic [7:0] t; logic e;} exp_t;
   exp_t exp_q[$];

   typedef struct {logic [2:0] op; logic [15:0] a; logic [15:0] b; logic [15:0] d; logic e;} vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready) begin
         exp_t e;
         checks++;
         nres++;
         last_tag = bus.res_tag;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got data=%0h tag=%0d err=%0b with none expected",
                     bus.res_data, bus.res_tag, bus.res_err);
         end else begin
            e = exp_q.pop_front();
            if (bus.res_data !== e.d || bus.res_tag !== e.t || bus.res_err !== e.e) begin
               errors++;
               $display("FAIL result: got data=%0h tag=%0d err=%0b expected data=%0h tag=%0d err=%0b",
                        bus.res_data, bus.res_tag, bus.res_err, e.d, e.t, e.e);
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic ee);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      @(negedge clk);
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: cmd_ready stayed 0, required 1");
      end else begin
         exp_q.push_back('{d: ed, t: tag_m, e: ee});
         tag_m++;
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic measure(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.res_valid && n < 50);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((bus.res_valid || busy || exp_q.size() != 0) && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= bound) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: busy=%0b pending=%0d after %0d cycles, required idle",
                  busy, exp_q.size(), n);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      exp_q.delete();
      tag_m  = 8'd0;
      last_a = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int lat, base;
      logic [2:0]  op;
      logic [15:0] a, b;
      logic        ee;

      tbl[0]  = '{3'd0, 16'd7,      16'd5,   16'd12,     1'b0};
      tbl[1]  = '{3'd1, 16'd10,     16'd3,   16'd7,      1'b0};
      tbl[2]  = '{3'd2, 16'd300,    16'd300, 16'd24464,  1'b0};
      tbl[3]  = '{3'd3, 16'd100,    16'd7,   16'd14,     1'b0};
      tbl[4]  = '{3'd4, 16'd100,    16'd7,   16'd2,      1'b0};
      tbl[5]  = '{3'd3, 16'd100,    16'd0,   16'hFFFF,   1'b1};
      tbl[6]  = '{3'd4, 16'd9,      16'd0,   16'd9,      1'b1};
      tbl[7]  = '{3'd6, 16'd5,      16'd6,   16'd0,      1'b1};
      tbl[8]  = '{3'd1, 16'd10,     16'd3,   16'd7,      1'b0};
      tbl[9]  = '{3'd0, 16'hFFFF,   16'd2,   16'd1,      1'b0};
      tbl[10] = '{3'd1, 16'd0,      16'd1,   16'hFFFF,   1'b0};
      tbl[11] = '{3'd7, 16'd1,      16'd1,   16'd0,      1'b1};

      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 3'd0;
      bus.cmd_a = 16'd0;
      bus.cmd_b = 16'd0;
      bus.res_ready = 1'b1;
      tag_m = 8'd0;
      last_a = 16'd0;
      #3;
      chk("rst_operation", bus.operation, 0);
      chk("rst_opa", bus.opa_calc, 0);
      chk("rst_opb", bus.opb_calc, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_tag", bus.res_tag, 0);
      chk("rst_res_err", bus.res_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      do_reset();

      // Vector table, one command at a time into an empty FIFO with res_ready high
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e);
         measure(lat);
         chk($sformatf("latency[%0d]", i), lat, tbl[i].e ? 1 : 3);
         if (tbl[i].e) begin
            chk($sformatf("opa_held[%0d]", i), bus.opa_calc, last_a);
         end else begin
            chk($sformatf("opa_loaded[%0d]", i), bus.opa_calc, tbl[i].a);
            chk($sformatf("opb_loaded[%0d]", i), bus.opb_calc, tbl[i].b);
            chk($sformatf("op_loaded[%0d]", i), bus.operation, tbl[i].op);
            last_a = tbl[i].a;
         end
         wait_idle(50);
         chk($sformatf("busy_idle[%0d]", i), busy, 0);
      end

      // Burst of five with the consumer stalled: fifth fills the FIFO
      do_reset();
      bus.res_ready = 1'b0;
      base = nres;
      for (int i = 0; i < 5; i++) send(3'd0, 16'(i), 16'(i), 16'(2 * i), 1'b0);
      @(negedge clk);
      chk("burst_full_cmd_ready", bus.cmd_ready, 0);
      chk("burst_busy", busy, 1);
      chk("burst_held_valid", bus.res_valid, 1);
      chk("burst_held_tag", bus.res_tag, 0);
      bus.res_ready = 1'b1;
      wait_idle(100);
      chk("burst_result_count", nres - base, 5);
      chk("burst_cmd_ready_after", bus.cmd_ready, 1);

      // Reset while in WAIT with two entries queued
      do_reset();
      bus.res_ready = 1'b0;
      send(3'd1, 16'd5, 16'd1, 16'd4, 1'b0);
      send(3'd0, 16'd1, 16'd2, 16'd3, 1'b0);
      send(3'd2, 16'd2, 16'd3, 16'd6, 1'b0);
      chk("pre_rst_operation", bus.operation, 1);
      chk("pre_rst_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_operation", bus.operation, 0);
      chk("midrst_opa", bus.opa_calc, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_cmd_ready", bus.cmd_ready, 1);
      chk("midrst_res_valid", bus.res_valid, 0);
      exp_q.delete();
      tag_m = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.res_ready = 1'b1;
      ee = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.res_valid) ee = 1'b1;
      end
      chk("no_result_after_reset", ee, 0);
      chk("post_rst_busy", busy, 0);

      // 257 mixed commands so the tag wraps back to 0
      do_reset();
      base = nres;
      for (int i = 0; i < 257; i++) begin
         op = 3'($urandom_range(0, 5));
         a  = 16'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         ee = (op > 3'd4) || ((op == 3'd3 || op == 3'd4) && b == 16'd0);
         send(op, a, b, calc(op, a, b), ee);
      end
      wait_idle(200);
      chk("wrap_result_count", nres - base, 257);
      chk("wrap_last_tag", last_tag, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
